// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 buffered stream demultiplexer and its
// per-output queues.
package demux_pkg;

    localparam int QDEPTH = 2;

    typedef logic [1:0] qcount_t;
    typedef logic       qptr_t;

endpackage

// File: rtl/queue2_buf.sv
// Two-entry val/rdy FIFO with registered output and no bypass path.
// A full queue refuses enqueue even when it dequeues in the same cycle.
module queue2_buf
    import demux_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_val,
    output logic             enq_rdy,
    input  logic [NBITS-1:0] enq_msg,
    output logic             deq_val,
    input  logic             deq_rdy,
    output logic [NBITS-1:0] deq_msg
);

    logic [NBITS-1:0] entry_q [QDEPTH];
    qcount_t          count_q, count_d;
    qptr_t            head_q, head_d;
    qptr_t            tail_q, tail_d;
    logic             enq, deq;

    assign enq_rdy = !rst && (count_q != qcount_t'(QDEPTH));
    assign deq_val = (count_q != '0);
    assign deq_msg = deq_val ? entry_q[head_q] : '0;

    assign enq = enq_val && enq_rdy;
    assign deq = deq_val && deq_rdy && !rst;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (enq) begin
            tail_d = ~tail_q;
        end
        if (deq) begin
            head_d = ~head_q;
        end
        if (enq && !deq) begin
            count_d = count_q + 2'd1;
        end else if (deq && !enq) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (enq) begin
                entry_q[tail_q] <= enq_msg;
            end
        end
    end

endmodule

// File: rtl/demux2_4b_buf.sv
// Registered 1-to-2 stream demultiplexer: steers each input message to one
// of two private queues so a stalled consumer never blocks the other.
module demux2_4b_buf
    import demux_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic             in_sel,
    input  logic [NBITS-1:0] in_msg,
    output logic             out0_val,
    input  logic             out0_rdy,
    output logic [NBITS-1:0] out0_msg,
    output logic             out1_val,
    input  logic             out1_rdy,
    output logic [NBITS-1:0] out1_msg
);

    logic enq0_rdy, enq1_rdy;

    // in_rdy looks only at the selected queue's state, never at in_val.
    assign in_rdy = in_sel ? enq1_rdy : enq0_rdy;

    queue2_buf #(.NBITS(NBITS)) u_q0 (
        .clk     (clk),
        .rst     (rst),
        .enq_val (in_val && !in_sel),
        .enq_rdy (enq0_rdy),
        .enq_msg (in_msg),
        .deq_val (out0_val),
        .deq_rdy (out0_rdy),
        .deq_msg (out0_msg)
    );

    queue2_buf #(.NBITS(NBITS)) u_q1 (
        .clk     (clk),
        .rst     (rst),
        .enq_val (in_val && in_sel),
        .enq_rdy (enq1_rdy),
        .enq_msg (in_msg),
        .deq_val (out1_val),
        .deq_rdy (out1_rdy),
        .deq_msg (out1_msg)
    );

endmodule

// File: tb/tb_demux2_4b_buf.sv
// Directed self-checking bench for demux2_4b_buf: inputs change and outputs
// are checked on the falling edge, state advances on the rising edge.
module tb_demux2_4b_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_val, in_rdy, in_sel;
    logic [3:0] in_msg;
    logic       out0_val, out0_rdy, out1_val, out1_rdy;
    logic [3:0] out0_msg, out1_msg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux2_4b_buf #(.NBITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_sel   (in_sel),
        .in_msg   (in_msg),
        .out0_val (out0_val),
        .out0_rdy (out0_rdy),
        .out0_msg (out0_msg),
        .out1_val (out1_val),
        .out1_rdy (out1_rdy),
        .out1_msg (out1_msg)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_val = 1'b1; in_sel = 1'b0; in_msg = 4'h5;
        out0_rdy = 1'b1; out1_rdy = 1'b1;
        tick();
        tick();
        checks++; if (out0_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_out0_val got=%b exp=0", out0_val); end
        checks++; if (out1_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_out1_val got=%b exp=0", out1_val); end
        checks++; if (out0_msg !== 4'h0) begin failures++; $display("[TB] FAIL reset_out0_msg got=%h exp=0", out0_msg); end
        checks++; if (out1_msg !== 4'h0) begin failures++; $display("[TB] FAIL reset_out1_msg got=%h exp=0", out1_msg); end
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_rdy_sel0 got=%b exp=0", in_rdy); end
        in_sel = 1'b1; settle();
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_rdy_sel1 got=%b exp=0", in_rdy); end
        rst = 1'b0; in_val = 1'b0; settle();
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_rdy got=%b exp=1", in_rdy); end
        tick();
        checks++; if (out1_val !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_no_enq got=%b exp=0", out1_val); end
    endtask

    task automatic test_routing();
        out0_rdy = 1'b1; out1_rdy = 1'b1;
        in_val = 1'b1; in_sel = 1'b0; in_msg = 4'h3; settle();
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("[TB] FAIL route_in_rdy0 got=%b exp=1", in_rdy); end
        tick();
        checks++; if ({out0_val, out0_msg} !== {1'b1, 4'h3}) begin failures++; $display("[TB] FAIL route_out0 got=%b/%h exp=1/3", out0_val, out0_msg); end
        checks++; if (out1_val !== 1'b0) begin failures++; $display("[TB] FAIL route_no_cross1 got=%b exp=0", out1_val); end
        in_sel = 1'b1; in_msg = 4'h9;
        tick();
        checks++; if ({out1_val, out1_msg} !== {1'b1, 4'h9}) begin failures++; $display("[TB] FAIL route_out1 got=%b/%h exp=1/9", out1_val, out1_msg); end
        checks++; if (out0_val !== 1'b0) begin failures++; $display("[TB] FAIL route_no_cross0 got=%b exp=0", out0_val); end
        in_val = 1'b0;
        tick();
        checks++; if ({out0_val, out1_val} !== 2'b00) begin failures++; $display("[TB] FAIL route_drained got=%b exp=00", {out0_val, out1_val}); end
    endtask

    task automatic test_backpressure();
        out0_rdy = 1'b0; out1_rdy = 1'b1;
        in_val = 1'b1; in_sel = 1'b0; in_msg = 4'h1;
        tick();
        in_msg = 4'h2; settle();
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_rdy got=%b exp=1", in_rdy); end
        tick();
        in_msg = 4'h4; settle();
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_rdy got=%b exp=0", in_rdy); end
        checks++; if (out0_msg !== 4'h1) begin failures++; $display("[TB] FAIL bp_head1 got=%h exp=1", out0_msg); end
        tick();
        out0_rdy = 1'b1; settle();
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_with_deq got=%b exp=0", in_rdy); end
        tick();
        checks++; if ({out0_val, out0_msg} !== {1'b1, 4'h2}) begin failures++; $display("[TB] FAIL bp_head2 got=%b/%h exp=1/2", out0_val, out0_msg); end
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("[TB] FAIL bp_rdy_after_deq got=%b exp=1", in_rdy); end
        tick();
        checks++; if ({out0_val, out0_msg} !== {1'b1, 4'h4}) begin failures++; $display("[TB] FAIL bp_head4 got=%b/%h exp=1/4", out0_val, out0_msg); end
        in_val = 1'b0;
        tick();
        checks++; if ({out0_val, out0_msg} !== {1'b0, 4'h0}) begin failures++; $display("[TB] FAIL bp_empty got=%b/%h exp=0/0", out0_val, out0_msg); end
    endtask

    task automatic test_independence();
        out0_rdy = 1'b0; out1_rdy = 1'b1;
        in_val = 1'b1; in_sel = 1'b0; in_msg = 4'hB;
        tick();
        in_msg = 4'hC;
        tick();
        in_sel = 1'b1; in_msg = 4'hA; settle();
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("[TB] FAIL indep_in_rdy got=%b exp=1", in_rdy); end
        tick();
        checks++; if ({out1_val, out1_msg} !== {1'b1, 4'hA}) begin failures++; $display("[TB] FAIL indep_out1 got=%b/%h exp=1/a", out1_val, out1_msg); end
        checks++; if ({out0_val, out0_msg} !== {1'b1, 4'hB}) begin failures++; $display("[TB] FAIL indep_out0_held got=%b/%h exp=1/b", out0_val, out0_msg); end
        in_val = 1'b0; in_sel = 1'b0; settle();
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("[TB] FAIL indep_out0_full got=%b exp=0", in_rdy); end
        tick();
        checks++; if (out1_val !== 1'b0) begin failures++; $display("[TB] FAIL indep_out1_drain got=%b exp=0", out1_val); end
        out0_rdy = 1'b1;
        tick();
        checks++; if (out0_msg !== 4'hC) begin failures++; $display("[TB] FAIL indep_out0_second got=%h exp=c", out0_msg); end
        tick();
        checks++; if (out0_val !== 1'b0) begin failures++; $display("[TB] FAIL indep_out0_drain got=%b exp=0", out0_val); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        out0_rdy = 1'b1; out1_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            in_val = 1'b1; in_sel = v[0]; in_msg = v; settle();
            checks++; if (in_rdy !== 1'b1) begin failures++; $display("[TB] FAIL stream_rdy[%0d] got=%b exp=1", i, in_rdy); end
            tick();
            if (v[0] == 1'b0) begin
                checks++; if ({out0_val, out0_msg, out1_val} !== {1'b1, v, 1'b0}) begin failures++; $display("[TB] FAIL stream_out0[%0d] got=%b/%h/%b exp=1/%h/0", i, out0_val, out0_msg, out1_val, v); end
            end else begin
                checks++; if ({out1_val, out1_msg, out0_val} !== {1'b1, v, 1'b0}) begin failures++; $display("[TB] FAIL stream_out1[%0d] got=%b/%h/%b exp=1/%h/0", i, out1_val, out1_msg, out0_val, v); end
            end
        end
        in_val = 1'b0;
        tick();
        checks++; if ({out0_val, out1_val} !== 2'b00) begin failures++; $display("[TB] FAIL stream_drained got=%b exp=00", {out0_val, out1_val}); end
    endtask

    task automatic test_reset_mid();
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        in_val = 1'b1;
        in_sel = 1'b0; in_msg = 4'h5; tick();
        in_msg = 4'h6; tick();
        in_sel = 1'b1; in_msg = 4'h7; tick();
        in_msg = 4'h8; settle();
        tick();
        checks++; if ({out0_val, out0_msg, out1_val, out1_msg} !== {1'b1, 4'h5, 1'b1, 4'h7}) begin failures++; $display("[TB] FAIL mid_filled got=%b/%h/%b/%h exp=1/5/1/7", out0_val, out0_msg, out1_val, out1_msg); end
        in_val = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; settle();
        checks++; if ({out0_val, out0_msg, out1_val, out1_msg} !== 10'b0) begin failures++; $display("[TB] FAIL mid_reset_cleared got=%b/%h/%b/%h exp=0/0/0/0", out0_val, out0_msg, out1_val, out1_msg); end
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_rdy got=%b exp=1", in_rdy); end
        in_val = 1'b1; in_sel = 1'b1; in_msg = 4'hE;
        tick();
        checks++; if ({out1_val, out1_msg} !== {1'b1, 4'hE}) begin failures++; $display("[TB] FAIL mid_post_out1 got=%b/%h exp=1/e", out1_val, out1_msg); end
        in_sel = 1'b0; in_msg = 4'hD;
        tick();
        checks++; if ({out0_val, out0_msg} !== {1'b1, 4'hD}) begin failures++; $display("[TB] FAIL mid_post_out0 got=%b/%h exp=1/d", out0_val, out0_msg); end
        in_val = 1'b0; out0_rdy = 1'b1; out1_rdy = 1'b1;
        tick();
        checks++; if ({out0_val, out1_val} !== 2'b00) begin failures++; $display("[TB] FAIL mid_no_stale got=%b exp=00", {out0_val, out1_val}); end
    endtask

    initial begin
        rst = 1'b1; in_val = 1'b0; in_sel = 1'b0; in_msg = 4'h0;
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
